// File: rtl/multihit_serializer.sv
// multihit_serializer
//
// Replays a match/request vector (e.g. CAM hit vector) as a stream of
// one-hot beats, lowest set index first, one beat per output handshake.
// All-zero vectors are absorbed and counted in a saturating counter.
//
// Parameters:
//   N      vector width (>= 2)
//   CNT_W  width of the zero-vector counter
//   IDX_W  derived index width, $clog2(N)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_vec              match vector
//   in_exactly_one      detector flag: one bit set
//   in_more_than_one    detector flag: two or more bits set
//   out_valid/out_ready output beat handshake
//   out_onehot, out_idx current beat and its binary index
//   out_last            final beat of the current vector
//   out_multi           current vector had two or more bits set
//   zero_cnt            saturating count of accepted zero vectors
//   err                 sticky flag/vector mismatch
//
// Optional feature: define MHS_FLAG_CHECK_EN to build the popcount check
// that drives err; otherwise err is tied to 0.
//
// State  | meaning
// IDLE   | no beat presented, waiting for a vector
// DRAIN  | beat presented; rem_q holds bits not yet emitted

module multihit_serializer #(
    parameter int  N     = 8,
    parameter int  CNT_W = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    input  logic             in_exactly_one,
    input  logic             in_more_than_one,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_onehot,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_multi,
    output logic [CNT_W-1:0] zero_cnt,
    output logic             err
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       rem_q, rem_d;
    logic [N-1:0]       onehot_q, onehot_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic               multi_q, multi_d;
    logic [CNT_W-1:0]   zero_cnt_q, zero_cnt_d;

    logic               accept;
    logic               out_hs;
    logic [N-1:0]       in_low, rem_low;
    logic [IDX_W-1:0]   in_low_idx, rem_low_idx;

    function automatic logic [IDX_W-1:0] low_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        // Scan downwards so the lowest set bit is the one left in r.
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign out_valid = (state_q == DRAIN);
    assign in_ready  = !rst && ((state_q == IDLE) ||
                                ((state_q == DRAIN) && out_ready && last_q));
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Two's-complement trick isolates the lowest set bit.
    assign in_low      = in_vec & (~in_vec + N'(1));
    assign rem_low     = rem_q & (~rem_q + N'(1));
    assign in_low_idx  = low_idx(in_vec);
    assign rem_low_idx = low_idx(rem_q);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        onehot_d   = onehot_q;
        idx_d      = idx_q;
        last_d     = last_q;
        multi_d    = multi_q;
        zero_cnt_d = zero_cnt_q;

        if (accept && (in_vec != '0)) begin
            state_d  = DRAIN;
            onehot_d = in_low;
            idx_d    = in_low_idx;
            rem_d    = in_vec & ~in_low;
            last_d   = in_exactly_one;
            multi_d  = in_more_than_one;
        end else begin
            if (accept && (zero_cnt_q != '1)) begin
                zero_cnt_d = zero_cnt_q + CNT_W'(1);
            end
            // Draining follows rem_q, not out_last: if the upstream flags
            // claimed a single hit for a multi-hit vector, the remaining
            // bits are still emitted rather than silently dropped.
            if (out_hs) begin
                if (rem_q != '0) begin
                    onehot_d = rem_low;
                    idx_d    = rem_low_idx;
                    rem_d    = rem_q & ~rem_low;
                    last_d   = ((rem_q & ~rem_low) == '0);
                end else begin
                    state_d  = IDLE;
                    onehot_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            onehot_q   <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            multi_q    <= 1'b0;
            zero_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            onehot_q   <= onehot_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            multi_q    <= multi_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign out_onehot = onehot_q;
    assign out_idx    = idx_q;
    assign out_last   = last_q;
    assign out_multi  = multi_q;
    assign zero_cnt   = zero_cnt_q;

`ifdef MHS_FLAG_CHECK_EN
    logic             err_q, err_d;
    logic [IDX_W:0]   pop;
    logic             flag_bad;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + (IDX_W + 1)'(in_vec[i]);
        end
        flag_bad = (in_exactly_one   != (pop == (IDX_W + 1)'(1))) ||
                   (in_more_than_one != (pop >= (IDX_W + 1)'(2)));
        err_d    = err_q || (accept && flag_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multihit_serializer.sv
module tb_multihit_serializer;

    localparam int N     = 8;
    localparam int CNT_W = 8;
    localparam int IDX_W = $clog2(N);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_vec;
    logic             in_exactly_one;
    logic             in_more_than_one;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_onehot;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_multi;
    logic [CNT_W-1:0] zero_cnt;
    logic             err;

    int n_checks;
    int n_errors;

`ifdef MHS_FLAG_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    multihit_serializer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_vec           (in_vec),
        .in_exactly_one   (in_exactly_one),
        .in_more_than_one (in_more_than_one),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_onehot       (out_onehot),
        .out_idx          (out_idx),
        .out_last         (out_last),
        .out_multi        (out_multi),
        .zero_cnt         (zero_cnt),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] vec, input logic e1, input logic m1);
        in_valid         = v;
        in_vec           = vec;
        in_exactly_one   = e1;
        in_more_than_one = m1;
    endtask

    task automatic check_beat(input string tag, input logic [IDX_W-1:0] idx,
                              input logic last, input logic multi);
        check({tag, "_valid"},  32'(out_valid), 32'd1);
        check({tag, "_idx"},    32'(out_idx), 32'(idx));
        check({tag, "_onehot"}, 32'(out_onehot), 32'(8'd1 << idx));
        check({tag, "_last"},   32'(out_last), 32'(last));
        check({tag, "_multi"},  32'(out_multi), 32'(multi));
    endtask

    initial begin
        int saw_valid;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // reset state
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_onehot", 32'(out_onehot), 32'd0);
        check("rst_idx",    32'(out_idx), 32'd0);
        check("rst_last",   32'(out_last), 32'd0);
        check("rst_multi",  32'(out_multi), 32'd0);
        check("rst_zcnt",   32'(zero_cnt), 32'd0);
        check("rst_err",    32'(err), 32'd0);
        check("rst_ready",  32'(in_ready), 32'd1);

        // single hit
        out_ready = 1'b1;
        drive(1'b1, 8'b0001_0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_beat("single", 3'd4, 1'b1, 1'b0);
        tick();
        check("single_done_valid",  32'(out_valid), 32'd0);
        check("single_done_onehot", 32'(out_onehot), 32'd0);

        // multi hit with stall
        out_ready = 1'b0;
        drive(1'b1, 8'b1010_0010, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_beat("stall", 3'd1, 1'b0, 1'b1);
            check("stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_beat("multi_b0", 3'd1, 1'b0, 1'b1);
        tick();
        check_beat("multi_b1", 3'd5, 1'b0, 1'b1);
        tick();
        check_beat("multi_b2", 3'd7, 1'b1, 1'b1);
        tick();
        check("multi_done_valid", 32'(out_valid), 32'd0);

        // back-to-back
        drive(1'b1, 8'b0000_0011, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'b1000_0000, 1'b1, 1'b0);
        #1;
        check_beat("b2b_b0", 3'd0, 1'b0, 1'b1);
        check("b2b_ready0", 32'(in_ready), 32'd0);
        tick();
        check_beat("b2b_b1", 3'd1, 1'b1, 1'b1);
        check("b2b_ready1", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_beat("b2b_b2", 3'd7, 1'b1, 1'b0);
        tick();
        check("b2b_done_valid", 32'(out_valid), 32'd0);

        // zero vectors, saturating count
        saw_valid = 0;
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (out_valid) saw_valid++;
            if (i == 4) check("zero_cnt5", 32'(zero_cnt), 32'd5);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("zero_no_valid", 32'(saw_valid), 32'd0);
        check("zero_cnt_sat",  32'(zero_cnt), 32'd255);

        // reset mid-drain
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_beat("rd_b0", 3'd0, 1'b0, 1'b1);
        tick();
        check_beat("rd_b1", 3'd1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check("rd_ready_in_rst", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rd_valid",  32'(out_valid), 32'd0);
        check("rd_onehot", 32'(out_onehot), 32'd0);
        check("rd_idx",    32'(out_idx), 32'd0);
        check("rd_last",   32'(out_last), 32'd0);
        check("rd_multi",  32'(out_multi), 32'd0);
        check("rd_zcnt",   32'(zero_cnt), 32'd0);
        drive(1'b1, 8'h04, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_beat("rd_after", 3'd2, 1'b1, 1'b0);
        tick();
        check("rd_after_done", 32'(out_valid), 32'd0);

        // inconsistent flags: two bits set but flagged as a single hit
        drive(1'b1, 8'b0000_0110, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("flag_err", 32'(err), 32'(ERR_EXP));
        check("flag_b0_valid", 32'(out_valid), 32'd1);
        check("flag_b0_idx",   32'(out_idx), 32'd1);
        tick();
        check_beat("flag_b1", 3'd2, 1'b1, 1'b0);
        tick();
        check("flag_done_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("flag_err_sticky", 32'(err), 32'(ERR_EXP));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
